pe_conv1d: RTL and testbench

3-tap 1D convolution processing element that produces the partial-sum stream consumed by the row accumulator stage. It holds three stationary weights, slides a 3-sample window over an incoming ifmap row and emits one 8-bit partial sum per complete window. `psum_valid` drives the accumulator's `en` and `psum_out` drives its `psum_in`.

---
 rtl/pe_conv1d_pkg.sv | 25 ++
 rtl/pe_conv1d_if.sv | 29 ++
 rtl/pe_conv1d_narrow.sv | 32 +++
 rtl/pe_conv1d.sv | 197 +++++++++++++++++++
 tb/tb_pe_conv1d.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_conv1d_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg : shared types and constants for the pe_conv1d processing element.
//   pe_state_t : FSM state encoding (IDLE, LOAD_W, FILL, RUN)
//   PE_DATA_W  : default sample / weight / psum width
//   PE_TAPS    : window length (only 3 is supported)
//   pe_sum_w() : width of the full-precision three-product sum
// -----------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        FILL   = 2'd2,
        RUN    = 2'd3
    } pe_state_t;

    localparam int PE_DATA_W = 8;
    localparam int PE_TAPS   = 3;

    // Three DATA_W x DATA_W products summed: 2*DATA_W bits plus two carry bits.
    function automatic int pe_sum_w(input int data_w);
        return (2 * data_w) + 2;
    endfunction

endpackage

// File: rtl/pe_conv1d_if.sv
// -----------------------------------------------------------------------------
// pe_conv1d_if : weight-load, ifmap-stream and psum-stream signals of the
// convolution PE.
//   master : the producer of weights / samples and consumer of psums
//   slave  : the pe_conv1d processing element
// -----------------------------------------------------------------------------
interface pe_conv1d_if #(
    parameter int DATA_W = 8
) ();
    logic              w_load;
    logic              w_valid;
    logic [DATA_W-1:0] w_in;
    logic              ifmap_valid;
    logic [DATA_W-1:0] ifmap_in;
    logic              ifmap_last;
    logic              ifmap_ready;
    logic [DATA_W-1:0] psum_out;
    logic              psum_valid;

    modport master (
        output w_load, w_valid, w_in, ifmap_valid, ifmap_in, ifmap_last,
        input  ifmap_ready, psum_out, psum_valid
    );

    modport slave (
        input  w_load, w_valid, w_in, ifmap_valid, ifmap_in, ifmap_last,
        output ifmap_ready, psum_out, psum_valid
    );
endinterface

// File: rtl/pe_conv1d_narrow.sv
// -----------------------------------------------------------------------------
// psum_narrow : combinational logical right shift of the full-precision sum
// followed by narrowing to DATA_W bits.
//   Macro PE_SATURATE_EN : defined -> clamp to 2^DATA_W-1, undefined -> wrap.
// Ports:
//   i_sum  [SUM_W-1:0]  : full-precision sum
//   o_psum [DATA_W-1:0] : shifted and narrowed partial sum
// -----------------------------------------------------------------------------
module psum_narrow #(
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 18,
    parameter int OUT_SHIFT = 0
) (
    input  logic [SUM_W-1:0]  i_sum,
    output logic [DATA_W-1:0] o_psum
);
    logic [SUM_W-1:0] w_shifted;

    // Shift, then either clamp or keep the low bits.
    always_comb begin
        w_shifted = i_sum >> OUT_SHIFT;
`ifdef PE_SATURATE_EN
        if (|w_shifted[SUM_W-1:DATA_W]) begin
            o_psum = {DATA_W{1'b1}};
        end else begin
            o_psum = w_shifted[DATA_W-1:0];
        end
`else
        o_psum = w_shifted[DATA_W-1:0];
`endif
    end
endmodule

// File: rtl/pe_conv1d.sv
// -----------------------------------------------------------------------------
// pe_conv1d : 3-tap 1D convolution PE with stationary weights.
// Loads three weights, slides a 3-sample window over an ifmap row and emits
// one narrowed partial sum per complete window, two edges after the sample
// that completes it (stage 1: products, stage 2: sum + narrow).
//   Macro PE_SATURATE_EN (tested only inside psum_narrow) selects clamp vs wrap.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : pe_conv1d_if.slave (weight load, ifmap stream, psum stream)
// -----------------------------------------------------------------------------
module pe_conv1d
    import pe_pkg::*;
#(
    parameter int DATA_W    = PE_DATA_W,
    parameter int TAPS      = PE_TAPS,
    parameter int OUT_SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    pe_conv1d_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = pe_sum_w(DATA_W);

    pe_state_t          r_state;
    pe_state_t          w_state_nxt;

    logic [DATA_W-1:0]  r_w   [TAPS];
    logic [DATA_W-1:0]  r_win [TAPS];
    logic [1:0]         r_wcnt;
    logic [1:0]         r_cnt;       // samples held in the window (3 in RUN)

    logic               r_ready;
    logic               r_launch;    // window completed at the previous edge
    logic [PROD_W-1:0]  r_prod [TAPS];
    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_psum_out;
    logic               r_psum_valid;

    logic               w_acc;
    logic               w_wr;
    logic               w_launch;
    logic               w_ready_nxt;
    logic [SUM_W-1:0]   w_sum;
    logic [DATA_W-1:0]  w_psum_narrow;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a weight-load pulse overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.w_load) begin
            w_state_nxt = LOAD_W;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                LOAD_W: begin
                    if (bus.w_valid && (r_wcnt == 2'd2)) begin
                        w_state_nxt = FILL;
                    end else begin
                        w_state_nxt = LOAD_W;
                    end
                end
                FILL: begin
                    if (w_acc && !bus.ifmap_last && (r_cnt == 2'd2)) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
                RUN: begin
                    if (w_acc && bus.ifmap_last) begin
                        w_state_nxt = FILL;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output / strobe decode from the registered state.
    always_comb begin
        w_acc       = bus.ifmap_valid && r_ready;
        w_wr        = (r_state == LOAD_W) && bus.w_valid && !bus.w_load;
        w_ready_nxt = (w_state_nxt == FILL) || (w_state_nxt == RUN);
        // A window launches when the accepted sample leaves 3 samples held,
        // even if it is also the last of its row.
        if (w_acc && ((r_state == RUN) || ((r_state == FILL) && (r_cnt == 2'd2)))) begin
            w_launch = 1'b1;
        end else begin
            w_launch = 1'b0;
        end
    end

    // Weight registers, window shift register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                r_w[t]   <= '0;
                r_win[t] <= '0;
            end
            r_wcnt   <= 2'd0;
            r_cnt    <= 2'd0;
            r_ready  <= 1'b0;
            r_launch <= 1'b0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_launch <= w_launch;
            for (int t = 0; t < TAPS; t++) begin
                if (w_wr && (r_wcnt == 2'(t))) begin
                    r_w[t] <= bus.w_in;
                end
            end
            if (bus.w_load) begin
                r_wcnt <= 2'd0;
            end else if (w_wr) begin
                r_wcnt <= (r_wcnt == 2'd2) ? 2'd0 : (r_wcnt + 2'd1);
            end else begin
                r_wcnt <= r_wcnt;
            end
            if (w_acc) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= bus.ifmap_in;
            end
            if (bus.w_load) begin
                r_cnt <= 2'd0;
            end else if (w_acc && bus.ifmap_last) begin
                r_cnt <= 2'd0;
            end else if (w_acc && (r_state == FILL)) begin
                r_cnt <= r_cnt + 2'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Stage 1: register the three products of the window launched last edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                r_prod[t] <= '0;
            end
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_launch;
            if (r_launch) begin
                for (int t = 0; t < TAPS; t++) begin
                    r_prod[t] <= PROD_W'(r_w[t]) * PROD_W'(r_win[t]);
                end
            end
        end
    end

    assign w_sum = SUM_W'(r_prod[0]) + SUM_W'(r_prod[1]) + SUM_W'(r_prod[2]);

    psum_narrow #(
        .DATA_W    (DATA_W),
        .SUM_W     (SUM_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_narrow (
        .i_sum  (w_sum),
        .o_psum (w_psum_narrow)
    );

    // Stage 2: sum, narrow and register the outputs; psum_out holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psum_out   <= '0;
            r_psum_valid <= 1'b0;
        end else begin
            r_psum_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_psum_out <= w_psum_narrow;
            end
        end
    end

    assign bus.ifmap_ready = r_ready;
    assign bus.psum_out    = r_psum_out;
    assign bus.psum_valid  = r_psum_valid;

endmodule

// File: tb/tb_pe_conv1d.sv
module tb_pe_conv1d;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   q_val[$];
    int   q_cyc[$];
    int   acc_cyc;
    int   a3, a4, a5;

    typedef struct {
        string name;
        int w0, w1, w2;
        int s0, s1, s2;
        int exp;
    } vec_t;

    vec_t vecs[5];

    pe_conv1d_if #(.DATA_W(8)) bus ();

    pe_conv1d #(.DATA_W(8), .TAPS(3), .OUT_SHIFT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.psum_valid) begin
            q_val.push_back(int'(bus.psum_out));
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_w(input int a, input int b, input int c);
        bus.w_load = 1'b1;
        tick();
        bus.w_load  = 1'b0;
        bus.w_valid = 1'b1;
        bus.w_in = 8'(a); tick();
        bus.w_in = 8'(b); tick();
        bus.w_in = 8'(c); tick();
        bus.w_valid = 1'b0;
    endtask

    task automatic send(input int x, input logic last, output int at);
        bus.ifmap_valid = 1'b1;
        bus.ifmap_in    = 8'(x);
        bus.ifmap_last  = last;
        tick();
        at = cyc;
        bus.ifmap_valid = 1'b0;
        bus.ifmap_last  = 1'b0;
    endtask

    initial begin
        int dummy;
        int ovf;
`ifdef PE_SATURATE_EN
        ovf = 255;
`else
        ovf = 3;
`endif
        vecs[0] = '{"basic123",  1, 2, 3,   1, 2, 3,  14};
        vecs[1] = '{"overflow", 255, 255, 255, 255, 255, 255, ovf};
        vecs[2] = '{"win456",    1, 2, 3,   4, 5, 6,  32};
        vecs[3] = '{"zero_tap",  2, 0, 1,  10, 20, 30, 50};
        vecs[4] = '{"tap_order", 0, 0, 7,   9, 9, 5,  35};

        bus.w_load = 1'b0; bus.w_valid = 1'b0; bus.w_in = 8'd0;
        bus.ifmap_valid = 1'b0; bus.ifmap_in = 8'd0; bus.ifmap_last = 1'b0;

        // Reset held two cycles.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_psum_out",   int'(bus.psum_out), 0);
        chk("rst_psum_valid", int'(bus.psum_valid), 0);
        chk("rst_ready",      int'(bus.ifmap_ready), 0);
        chk("rst_state",      int'(dut.r_state), int'(IDLE));

        // Samples offered in IDLE are ignored.
        for (int i = 0; i < 4; i++) send(i + 1, 1'b0, dummy);
        repeat (4) tick();
        chk("idle_no_psum", q_val.size(), 0);
        chk("idle_state",   int'(dut.r_state), int'(IDLE));

        // Table: one full window per row.
        foreach (vecs[i]) begin
            q_val.delete(); q_cyc.delete();
            load_w(vecs[i].w0, vecs[i].w1, vecs[i].w2);
            send(vecs[i].s0, 1'b0, dummy);
            send(vecs[i].s1, 1'b0, dummy);
            send(vecs[i].s2, 1'b1, acc_cyc);
            repeat (3) tick();
            chk({vecs[i].name, "_count"}, q_val.size(), 1);
            if (q_val.size() == 1) begin
                chk({vecs[i].name, "_value"}, q_val[0], vecs[i].exp);
                chk({vecs[i].name, "_latency"}, q_cyc[0], acc_cyc + 2);
            end
            chk({vecs[i].name, "_state"}, int'(dut.r_state), int'(FILL));
        end

        // Basic row of five samples: three windows.
        q_val.delete(); q_cyc.delete();
        load_w(1, 2, 3);
        send(1, 1'b0, dummy);
        send(2, 1'b0, dummy);
        send(3, 1'b0, a3);
        send(4, 1'b0, a4);
        send(5, 1'b1, a5);
        repeat (3) tick();
        chk("row5_count", q_val.size(), 3);
        if (q_val.size() == 3) begin
            chk("row5_p0", q_val[0], 14);
            chk("row5_p1", q_val[1], 20);
            chk("row5_p2", q_val[2], 26);
            chk("row5_t0", q_cyc[0], a3 + 2);
            chk("row5_t1", q_cyc[1], a4 + 2);
            chk("row5_t2", q_cyc[2], a5 + 2);
        end
        chk("row5_state", int'(dut.r_state), int'(FILL));

        // Short row gives nothing; next row gives one psum.
        q_val.delete(); q_cyc.delete();
        send(9, 1'b0, dummy);
        send(9, 1'b1, dummy);
        repeat (3) tick();
        chk("short_no_psum", q_val.size(), 0);
        send(4, 1'b0, dummy);
        send(5, 1'b0, dummy);
        send(6, 1'b1, dummy);
        repeat (3) tick();
        chk("after_short_count", q_val.size(), 1);
        if (q_val.size() == 1) chk("after_short_value", q_val[0], 32);

        // Reload in the cycle after sample 4 of a running row.
        q_val.delete(); q_cyc.delete();
        load_w(1, 2, 3);
        send(1, 1'b0, dummy);
        send(2, 1'b0, dummy);
        send(3, 1'b0, dummy);
        send(4, 1'b0, dummy);
        bus.w_load = 1'b1;
        tick();
        bus.w_load = 1'b0;
        chk("reload_ready_low0", int'(bus.ifmap_ready), 0);
        bus.w_valid = 1'b1;
        bus.w_in = 8'd0; tick();
        chk("reload_ready_low1", int'(bus.ifmap_ready), 0);
        bus.w_in = 8'd0; tick();
        chk("reload_ready_low2", int'(bus.ifmap_ready), 0);
        bus.w_in = 8'd1; tick();
        bus.w_valid = 1'b0;
        chk("reload_ready_high", int'(bus.ifmap_ready), 1);
        chk("reload_old_count", q_val.size(), 2);
        if (q_val.size() == 2) begin
            chk("reload_old_p0", q_val[0], 14);
            chk("reload_old_p1", q_val[1], 20);
        end
        send(7, 1'b0, dummy);
        send(8, 1'b0, dummy);
        send(9, 1'b1, dummy);
        repeat (3) tick();
        chk("reload_new_count", q_val.size(), 3);
        if (q_val.size() == 3) chk("reload_new_value", q_val[2], 9);
        chk("hold_psum_out",   int'(bus.psum_out), 9);
        chk("hold_psum_valid", int'(bus.psum_valid), 0);

        // Reset one edge after a window-completing sample.
        q_val.delete(); q_cyc.delete();
        load_w(1, 2, 3);
        send(1, 1'b0, dummy);
        send(2, 1'b0, dummy);
        send(3, 1'b0, dummy);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("rstrun_no_psum", q_val.size(), 0);
        chk("rstrun_state",   int'(dut.r_state), int'(IDLE));
        chk("rstrun_ready",   int'(bus.ifmap_ready), 0);
        chk("rstrun_psum_out", int'(bus.psum_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
